// File: rtl/barrel_pkg.sv
// barrel_pkg: op codes, fill-select encoding and per-beat control decode shared by the barrel shifter pipeline
package barrel_pkg;
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  typedef enum logic [1:0] {ZERO, SIGN, WRAP} fill_e;
  typedef struct packed {
    fill_e fill;
    logic  rev;
  } ctl_t;
  function automatic ctl_t decode(input logic [2:0] op);
    ctl_t c;
    c.fill = op == OP_SRA ? SIGN : (op == OP_ROL || op == OP_ROR) ? WRAP : ZERO;
    c.rev = op == OP_SLL || op == OP_ROL;
    return c;
  endfunction
  function automatic logic is_rsvd(input logic [2:0] op);
    return op > OP_ROR;
  endfunction
endpackage

// File: rtl/bshift_stage.sv
// bshift_stage: one right-shift level (by 2^LVL when in_amt[LVL]) plus its stall-enabled register; ports carry valid, data, amt and fill/reverse control
module bshift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LVL = 0,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  ctl_t             in_ctl,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output ctl_t             out_ctl
);
  localparam int S = 1 << LVL;
  logic [S-1:0] fill_bits;
  logic [WIDTH-1:0] shifted;
  always_comb begin
    fill_bits = in_ctl.fill == WRAP ? in_data[S-1:0] : in_ctl.fill == SIGN ? {S{in_data[WIDTH-1]}} : '0;
    shifted = in_amt[LVL] ? {fill_bits, in_data[WIDTH-1:S]} : in_data;
  end
  always_ff @(posedge clk)
    if (rst) out_valid <= 1'b0;
    else if (en) out_valid <= in_valid;
  always_ff @(posedge clk)
    if (en) begin
      out_data <= shifted;
      out_amt <= in_amt;
      out_ctl <= in_ctl;
    end
endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined shift/rotate (SLL/SRL/SRA/ROL/ROR) with valid/ready handshake; in_* beat in, out_* result with out_zero flag, latency SHW+1
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  logic             v [SHW+1];
  logic [WIDTH-1:0] d [SHW+1];
  logic [SHW-1:0]   a [SHW+1];
  ctl_t             c [SHW+1];
  logic [WIDTH-1:0] pre, post;
  assign in_ready = !(out_valid && !out_ready);
  assign c[0] = decode(in_op);
  assign a[0] = is_rsvd(in_op) ? '0 : in_amt;
  assign v[0] = in_valid;
  assign d[0] = pre;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign pre[i] = c[0].rev ? in_data[WIDTH-1-i] : in_data[i];
    assign post[i] = c[SHW].rev ? d[SHW][WIDTH-1-i] : d[SHW][i];
  end
  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    bshift_stage #(.WIDTH(WIDTH), .LVL(k)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (in_ready),
      .in_valid (v[k]),
      .in_data  (d[k]),
      .in_amt   (a[k]),
      .in_ctl   (c[k]),
      .out_valid(v[k+1]),
      .out_data (d[k+1]),
      .out_amt  (a[k+1]),
      .out_ctl  (c[k+1])
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_zero <= 1'b0;
    end else if (in_ready) begin
      out_valid <= v[SHW];
      out_data <= post;
      out_zero <= ~|post;
    end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: table-driven and sequence checks of barrel_shifter_pipe at WIDTH=32
module tb_barrel_shifter_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_data, out_data;
  logic [4:0] in_amt;
  logic [2:0] in_op;
  int errors = 0, checks = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] exp;
    logic        z;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  barrel_shifter_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [4:0] a);
    case (op)
      3'd0: return x << a;
      3'd1: return x >> a;
      3'd2: return $signed(x) >>> a;
      3'd3: return (x << a) | (x >> (32 - a));
      3'd4: return (x >> a) | (x << (32 - a));
      default: return x;
    endcase
  endfunction
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    in_op = v.op;
    in_data = v.d;
    in_amt = v.a;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk({name, "_lat"}, lat, 6);
    chk({name, "_data"}, out_data, v.exp);
    chk({name, "_zero"}, {31'd0, out_zero}, {31'd0, v.z});
    tick;
  endtask
  task automatic run_stream(input int n, input int st, input int sl, input string name);
    logic [2:0] bo[$];
    logic [31:0] bd[$], ex[$];
    logic [4:0] ba[$];
    int sent, got, cyc, first, last, extra;
    logic hold, hold_z;
    logic [31:0] hold_d;
    for (int i = 0; i < n; i++) begin
      bo.push_back(3'($urandom_range(0, 7)));
      bd.push_back($urandom);
      ba.push_back(5'($urandom_range(0, 31)));
      ex.push_back(model(bo[i], bd[i], ba[i]));
    end
    sent = 0; got = 0; cyc = 0; first = -1; last = -1; hold = 1'b0; hold_d = '0; hold_z = 1'b0;
    while (got < n && cyc < 300) begin
      in_valid = sent < n;
      if (sent < n) begin
        in_op = bo[sent];
        in_data = bd[sent];
        in_amt = ba[sent];
      end
      out_ready = !(cyc >= st && cyc < st + sl);
      #1;
      if (hold) begin
        chk({name, "_hold_data"}, out_data, hold_d);
        chk({name, "_hold_zero"}, {31'd0, out_zero}, {31'd0, hold_z});
      end
      if (out_valid && !out_ready) chk({name, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk({name, "_data"}, out_data, ex[got]);
        chk({name, "_zero"}, {31'd0, out_zero}, {31'd0, ex[got] == 32'd0});
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      hold = out_valid && !out_ready;
      hold_d = out_data;
      hold_z = out_zero;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({name, "_count"}, got, n);
    if (sl == 0) chk({name, "_b2b"}, last - first, n - 1);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid) extra++;
    end
    chk({name, "_extra"}, extra, 0);
  endtask
  initial begin
    int leak;
    tbl[0]  = '{3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    tbl[1]  = '{3'd2, 32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0};
    tbl[2]  = '{3'd1, 32'h8000_00F0, 5'd4,  32'h0800_000F, 1'b0};
    tbl[3]  = '{3'd3, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0};
    tbl[4]  = '{3'd4, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0};
    tbl[5]  = '{3'd6, 32'h1234_5678, 5'd8,  32'h1234_5678, 1'b0};
    tbl[6]  = '{3'd7, 32'hA5A5_A5A5, 5'd31, 32'hA5A5_A5A5, 1'b0};
    tbl[7]  = '{3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
    tbl[8]  = '{3'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1};
    tbl[9]  = '{3'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{3'd4, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1'b0};
    tbl[11] = '{3'd3, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0};
    tbl[12] = '{3'd4, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0};
    tbl[13] = '{3'd0, 32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 1'b0};
    tbl[14] = '{3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
    tbl[15] = '{3'd5, 32'h0000_0000, 5'd3,  32'h0000_0000, 1'b1};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_amt = '0; in_op = '0;
    tick;
    tick;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_data", out_data, 32'd0);
    chk("reset_zero", {31'd0, out_zero}, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    run_stream(20, 1000, 0, "stream");
    run_stream(20, 10, 5, "stall");
    for (int i = 0; i < 3; i++) begin
      in_op = 3'd0;
      in_data = 32'h0000_0001;
      in_amt = 5'(i + 1);
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_data", out_data, 32'd0);
    chk("flush_zero", {31'd0, out_zero}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    leak = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (out_valid) leak++;
    end
    chk("flush_leak", leak, 0);
    run_vec('{3'd1, 32'h0000_00FF, 5'd8, 32'h0000_0000, 1'b1}, "srl_zero");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
